// File: rtl/weight_reload_controller.sv
// Weight reload controller: copies the selected model image from the weight store into the weight buffer.
// Latency: 3 cycles per word with wbuf_ready high; load_done follows the request edge by 3*WORDS edges.
// Backpressure: WRITE holds address/data stable while wbuf_ready is low, with no timeout.
module weight_reload_controller #(
  parameter int WORDS  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int BASE_A = 0,
  parameter int BASE_B = 64,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload_weights,
  input  logic [1:0]        active_model,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              wbuf_wr_en,
  output logic [IDX_W-1:0]  wbuf_addr,
  output logic [DATA_W-1:0] wbuf_wr_data,
  input  logic              wbuf_ready,
  output logic              busy,
  output logic              load_done,
  output logic              weights_valid,
  output logic              cfg_error
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_data;
  logic              r_weights_valid;
  logic              r_cfg_error;

  logic              w_code_ok;
  logic              w_req_ok;
  logic              w_req_bad;
  logic [ADDR_W-1:0] w_base_sel;
  logic              w_last;

  // Only codes 01 (model A) and 10 (model B) name a model.
  assign w_code_ok  = (active_model == 2'b01) || (active_model == 2'b10);
  assign w_req_ok   = reload_weights && w_code_ok;
  assign w_req_bad  = reload_weights && !w_code_ok;
  assign w_base_sel = (active_model == 2'b10) ? ADDR_W'(BASE_B) : ADDR_W'(BASE_A);
  assign w_last     = (r_idx == IDX_W'(WORDS - 1));

  // Sequencer: a valid request always restarts from word 0, whatever state we are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_base  <= '0;
    end else if (w_req_ok) begin
      r_state <= ST_READ;
      r_idx   <= '0;
      r_base  <= w_base_sel;
    end else begin
      case (r_state)
        ST_READ:  r_state <= ST_WAIT;
        ST_WAIT:  r_state <= ST_WRITE;
        ST_WRITE: begin
          if (wbuf_ready) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_READ;
            end
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the store's read data on the edge closing WAIT; it is held through WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_state == ST_WAIT) begin
      r_data <= mem_rd_data;
    end
  end

  // weights_valid drops on any accepted request and rises only when DONE closes without a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weights_valid <= 1'b0;
    end else if (w_req_ok) begin
      r_weights_valid <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_weights_valid <= 1'b1;
    end
  end

  // Invalid model code: one-cycle error pulse in the cycle after the request, nothing else changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_error <= 1'b0;
    end else begin
      r_cfg_error <= w_req_bad;
    end
  end

  // Strobes and their payloads are decoded from state; payloads read zero when their strobe is low.
  assign mem_rd_en     = (r_state == ST_READ);
  assign mem_addr      = (r_state == ST_READ) ? (r_base + ADDR_W'(r_idx)) : '0;
  assign wbuf_wr_en    = (r_state == ST_WRITE);
  assign wbuf_addr     = (r_state == ST_WRITE) ? r_idx : '0;
  assign wbuf_wr_data  = (r_state == ST_WRITE) ? r_data : '0;
  assign busy          = (r_state != ST_IDLE);
  assign load_done     = (r_state == ST_DONE);
  assign weights_valid = r_weights_valid;
  assign cfg_error     = r_cfg_error;

endmodule

// File: tb/tb_weight_reload_controller.sv
// Bench for weight_reload_controller: WORDS=4, BASE_A=0, BASE_B=16, memory word at a = 0xA000_0000 + a.
// Expected write order, buffer image and completion time come from a per-word timing model of the load.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same settled point.
module tb_weight_reload_controller;
  localparam int WORDS  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int BASE_A = 0;
  localparam int BASE_B = 16;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              reload_weights = 1'b0;
  logic [1:0]        active_model = 2'b00;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              wbuf_wr_en;
  logic [IDX_W-1:0]  wbuf_addr;
  logic [DATA_W-1:0] wbuf_wr_data;
  logic              wbuf_ready = 1'b0;
  logic              busy;
  logic              load_done;
  logic              weights_valid;
  logic              cfg_error;

  weight_reload_controller #(
    .WORDS(WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_A(BASE_A), .BASE_B(BASE_B)
  ) dut (
    .clk(clk), .rst(rst), .reload_weights(reload_weights), .active_model(active_model),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .wbuf_wr_en(wbuf_wr_en), .wbuf_addr(wbuf_addr), .wbuf_wr_data(wbuf_wr_data),
    .wbuf_ready(wbuf_ready), .busy(busy), .load_done(load_done),
    .weights_valid(weights_valid), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  // Synchronous-read weight store.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 32'hA000_0000 + 32'(mem_addr);
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int total_done = 0;
  int wr_idx_q[$];
  logic [31:0] wr_dat_q[$];
  int done_q[$];
  int cfg_q[$];
  int rd_q[$];
  logic [31:0] wbuf [WORDS];
  bit rdy_sched [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record what the DUT does this cycle, then move to the next edge.
  task automatic tick();
    if (wbuf_wr_en && wbuf_ready) begin
      wr_idx_q.push_back(int'(wbuf_addr));
      wr_dat_q.push_back(wbuf_wr_data);
      wbuf[wbuf_addr] = wbuf_wr_data;
    end
    if (load_done) begin
      done_q.push_back(cyc);
      total_done++;
    end
    if (cfg_error) cfg_q.push_back(cyc);
    if (mem_rd_en) rd_q.push_back(int'(mem_addr));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int model_base(input logic [1:0] code);
    return (code == 2'b10) ? BASE_B : BASE_A;
  endfunction

  function automatic logic [31:0] model_word(input int base, input int k);
    return 32'hA000_0000 + 32'(base + k);
  endfunction

  // Cycles from the request edge to the DONE cycle: each word costs a read cycle, a wait
  // cycle, then write cycles until the buffer is ready.
  function automatic int model_finish();
    int t;
    t = 0;
    for (int k = 0; k < WORDS; k++) begin
      t += 2;
      while (t < 63 && !rdy_sched[t]) t++;
      t++;
    end
    return t;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/load_done"}, load_done, 0);
    check({tag, "/mem_rd_en"}, mem_rd_en, 0);
    check({tag, "/mem_addr"}, mem_addr, 0);
    check({tag, "/wbuf_wr_en"}, wbuf_wr_en, 0);
    check({tag, "/wbuf_addr"}, wbuf_addr, 0);
    check({tag, "/wbuf_wr_data"}, wbuf_wr_data, 0);
    check({tag, "/cfg_error"}, cfg_error, 0);
  endtask

  // Issue one request and run it to completion against rdy_sched; optionally pulse an
  // invalid code (00) at relative cycle inject.
  task automatic load_check(input string tag, input logic [1:0] code, input int inject);
    int base, t, req, busy_cnt, nw;
    base = model_base(code);
    t = model_finish();
    wr_idx_q.delete(); wr_dat_q.delete(); done_q.delete(); cfg_q.delete(); rd_q.delete();
    reload_weights = 1'b1;
    active_model = code;
    tick();
    reload_weights = 1'b0;
    active_model = 2'b00;
    req = cyc;
    check({tag, "/wv_drop"}, weights_valid, 0);
    busy_cnt = 0;
    for (int j = 0; j <= t; j++) begin
      wbuf_ready = rdy_sched[j];
      reload_weights = (j == inject);
      active_model = 2'b00;
      if (wbuf_wr_en) begin
        nw = wr_idx_q.size();
        check({tag, "/wbuf_addr"}, wbuf_addr, nw);
        check({tag, "/wbuf_data"}, wbuf_wr_data, model_word(base, nw));
      end
      if (j == t) begin
        check({tag, "/done_cycle_pulse"}, load_done, 1);
        check({tag, "/wv_in_done"}, weights_valid, 0);
      end
      if (busy) busy_cnt++;
      tick();
    end
    reload_weights = 1'b0;
    wbuf_ready = 1'b1;
    check({tag, "/wv_rise"}, weights_valid, 1);
    check({tag, "/busy_end"}, busy, 0);
    check({tag, "/done_end"}, load_done, 0);
    check({tag, "/n_done"}, done_q.size(), 1);
    check({tag, "/done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, req + t);
    check({tag, "/busy_cycles"}, busy_cnt, t + 1);
    check({tag, "/n_writes"}, wr_idx_q.size(), WORDS);
    check({tag, "/n_reads"}, rd_q.size(), WORDS);
    for (int k = 0; k < WORDS; k++) begin
      if (k < wr_idx_q.size()) begin
        check({tag, "/wr_idx"}, wr_idx_q[k], k);
        check({tag, "/wr_dat"}, wr_dat_q[k], model_word(base, k));
      end
      if (k < rd_q.size()) check({tag, "/rd_addr"}, rd_q[k], base + k);
      check({tag, "/wbuf_img"}, wbuf[k], model_word(base, k));
    end
    if (inject >= 0) begin
      check({tag, "/n_cfg"}, cfg_q.size(), 1);
      check({tag, "/cfg_cyc"}, (cfg_q.size() > 0) ? cfg_q[0] : -1, req + inject + 1);
    end else begin
      check({tag, "/n_cfg"}, cfg_q.size(), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int td0;
    for (int k = 0; k < WORDS; k++) wbuf[k] = '0;

    // Reset state
    tick(); tick();
    check_idle_outputs("reset");
    check("reset/wv", weights_valid, 0);
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset");
    check("post_reset/wv", weights_valid, 0);

    // 1: model A, buffer always ready
    for (int i = 0; i < 64; i++) rdy_sched[i] = 1'b1;
    load_check("t1_A", 2'b01, -1);

    // 2: model B, buffer always ready
    load_check("t2_B", 2'b10, -1);

    // 3: model A, buffer stalls 5 cycles during the word-2 WRITE
    for (int i = 8; i < 13; i++) rdy_sched[i] = 1'b0;
    check("t3/model_delay", model_finish(), 3 * WORDS + 5);
    load_check("t3_stall", 2'b01, -1);
    for (int i = 0; i < 64; i++) rdy_sched[i] = 1'b1;

    // 4: model A, re-targeted to B during word-1 WAIT
    td0 = total_done;
    wbuf_ready = 1'b1;
    reload_weights = 1'b1;
    active_model = 2'b01;
    tick();
    reload_weights = 1'b0;
    active_model = 2'b00;
    for (int j = 0; j < 4; j++) tick();
    check("t4/in_wait_busy", busy, 1);
    check("t4/in_wait_no_strobe", mem_rd_en | wbuf_wr_en, 0);
    load_check("t4_retarget", 2'b10, -1);
    check("t4/total_done", total_done - td0, 1);

    // 5: invalid code 11 in IDLE, then 00 in the middle of a load
    reload_weights = 1'b1;
    active_model = 2'b11;
    tick();
    reload_weights = 1'b0;
    active_model = 2'b00;
    check("t5/cfg_pulse", cfg_error, 1);
    check("t5/idle_busy", busy, 0);
    check("t5/idle_rd", mem_rd_en, 0);
    check("t5/idle_wv", weights_valid, 1);
    tick();
    check("t5/cfg_clear", cfg_error, 0);
    check("t5/still_idle", busy, 0);
    check("t5/wv_kept", weights_valid, 1);
    load_check("t5_bad_mid", 2'b01, 5);

    // 6: asynchronous reset during the word-2 WRITE
    wbuf_ready = 1'b1;
    reload_weights = 1'b1;
    active_model = 2'b01;
    tick();
    reload_weights = 1'b0;
    active_model = 2'b00;
    for (int j = 0; j < 8; j++) tick();
    check("t6/pre_wr_en", wbuf_wr_en, 1);
    check("t6/pre_wr_addr", wbuf_addr, 2);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    check("t6_async/wv", weights_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("t6_after");
    load_check("t6_restart", 2'b01, -1);

    // Randomized loads with random buffer backpressure
    for (int r = 0; r < 8; r++) begin
      logic [1:0] code;
      code = 2'($urandom_range(1, 2));
      for (int i = 0; i < 64; i++) rdy_sched[i] = (i >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      load_check("rand", code, (r % 3 == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
